// File: rtl/radix4_pkg.sv
// Shared Booth radix-4 definitions: digit encoding and the 3-bit window decoder.
package radix4_pkg;

   typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_digit_e;

   // Window bits are {b[2j+1], b[2j], b[2j-1]}.
   function automatic booth_digit_e decode_digit(input logic [2:0] bits);
      booth_digit_e d;
      case (bits)
         3'b001, 3'b010: d = P1;
         3'b011:         d = P2;
         3'b100:         d = M2;
         3'b101, 3'b110: d = M1;
         default:        d = ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Booth partial-product generator: selects 0, +/-MD or +/-2MD as a (W+2)-bit value
// from the multiplicand extended according to the signed/unsigned mode.
module booth_pp_gen
   import radix4_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] md,
   input  logic [2:0]   digit,
   input  logic         uns,
   output logic [W+1:0] pp
);

   logic [W+1:0] mdx;
   logic [W+1:0] md2x;

   // Two extra bits hold both 2*MD for the most negative operand and 2*(2^W-1).
   assign mdx  = {{2{~uns & md[W-1]}}, md};
   assign md2x = {mdx[W:0], 1'b0};

   always_comb begin
      pp = '0;
      case (decode_digit(digit))
         P1:      pp = mdx;
         P2:      pp = md2x;
         M1:      pp = -mdx;
         M2:      pp = -md2x;
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/radix4_pipe_mul.sv
// Pipelined radix-4 Booth multiplier, one Booth digit per stage, valid/ready at both ends.
// Define RADIX4_UNSIGNED_EN to add the uns_i port for per-pair unsigned operation.
module radix4_pipe_mul
   import radix4_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           valid_i,
   output logic           ready_o,
   input  logic [W-1:0]   MD_i,
   input  logic [W-1:0]   MR_i,
`ifdef RADIX4_UNSIGNED_EN
   input  logic           uns_i,
`endif
   output logic           valid_o,
   input  logic           ready_i,
   output logic [2*W-1:0] result_o
);

   localparam int D = W/2 + 1;

   // Index 0 is the operand capture register; index k holds the sum after digit k-1.
   logic [W-1:0]   md_reg  [0:D-1];
   logic [W-1:0]   mr_reg  [0:D-1];
   logic           uns_reg [0:D-1];
   logic           vld_reg [0:D];
   logic [2*W-1:0] sum_reg [1:D];
   logic [W+1:0]   pp      [1:D];
   logic           advance;
   logic           uns_in;

`ifdef RADIX4_UNSIGNED_EN
   assign uns_in = uns_i;
`else
   assign uns_in = 1'b0;
`endif

   assign advance  = ready_i || !vld_reg[D];
   assign ready_o  = advance;
   assign valid_o  = vld_reg[D];
   assign result_o = sum_reg[D];

   genvar gi;
   generate
      for (gi = 1; gi <= D; gi++) begin : g_stage
         // mrx[i+1] is bit i of the (W+2)-bit extended multiplier; mrx[0] is the implicit 0.
         logic [W+2:0] mrx;
         assign mrx = {{2{~uns_reg[gi-1] & mr_reg[gi-1][W-1]}}, mr_reg[gi-1], 1'b0};

         booth_pp_gen #(.W(W)) u_pp (
            .md    (md_reg[gi-1]),
            .digit (mrx[2*gi : 2*gi-2]),
            .uns   (uns_reg[gi-1]),
            .pp    (pp[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < D; k++) begin
            md_reg[k]  <= '0;
            mr_reg[k]  <= '0;
            uns_reg[k] <= 1'b0;
         end
         for (int k = 0; k <= D; k++) begin
            vld_reg[k] <= 1'b0;
         end
         for (int k = 1; k <= D; k++) begin
            sum_reg[k] <= '0;
         end
      end else if (advance) begin
         vld_reg[0] <= valid_i;
         md_reg[0]  <= MD_i;
         mr_reg[0]  <= MR_i;
         uns_reg[0] <= uns_in;
         vld_reg[1] <= vld_reg[0];
         sum_reg[1] <= {{(W-2){pp[1][W+1]}}, pp[1]};
         for (int k = 1; k < D; k++) begin
            md_reg[k]  <= md_reg[k-1];
            mr_reg[k]  <= mr_reg[k-1];
            uns_reg[k] <= uns_reg[k-1];
         end
         for (int k = 2; k <= D; k++) begin
            vld_reg[k] <= vld_reg[k-1];
            sum_reg[k] <= sum_reg[k-1] + ({{(W-2){pp[k][W+1]}}, pp[k]} << (2*(k-1)));
         end
      end
   end

endmodule

// File: tb/tb_radix4_pipe_mul.sv
// Self-checking bench: W=8 directed scenarios and a W=16 randomized stream against an
// arithmetic reference product.
module tb_radix4_pipe_mul;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        v8, rdy8, u8, vo8, ro8;
   logic [7:0]  md8, mr8;
   logic [15:0] res8;
   logic        v16, rdy16, u16, vo16, ro16;
   logic [15:0] md16, mr16;
   logic [31:0] res16;

   int checks = 0;
   int passed = 0;

   radix4_pipe_mul #(.W(8)) dut8 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v8), .ready_o(ro8),
      .MD_i(md8), .MR_i(mr8),
`ifdef RADIX4_UNSIGNED_EN
      .uns_i(u8),
`endif
      .valid_o(vo8), .ready_i(rdy8), .result_o(res8)
   );

   radix4_pipe_mul #(.W(16)) dut16 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(v16), .ready_o(ro16),
      .MD_i(md16), .MR_i(mr16),
`ifdef RADIX4_UNSIGNED_EN
      .uns_i(u16),
`endif
      .valid_o(vo16), .ready_i(rdy16), .result_o(res16)
   );

   // Reference: plain integer product of the operands interpreted per mode, mod 2^(2w).
   function automatic logic [31:0] ref_prod(input int w, input logic [15:0] a_in,
                                            input logic [15:0] b_in, input logic u);
      longint a, b, p, mask;
      mask = (longint'(1) << w) - 1;
      a = longint'(a_in) & mask;
      b = longint'(b_in) & mask;
      if (!u && a >= (longint'(1) << (w-1))) a = a - (longint'(1) << w);
      if (!u && b >= (longint'(1) << (w-1))) b = b - (longint'(1) << w);
      p = a * b;
      return 32'(p & ((longint'(1) << (2*w)) - 1));
   endfunction

   task automatic test_reset();
      checks++; if (vo8 !== 1'b0) $display("FAIL reset_valid8 got=%b want=0", vo8); else passed++;
      checks++; if (res8 !== 16'h0) $display("FAIL reset_result8 got=%h want=0000", res8); else passed++;
      checks++; if (ro8 !== 1'b1) $display("FAIL reset_ready8 got=%b want=1", ro8); else passed++;
      checks++; if (vo16 !== 1'b0 || res16 !== 32'h0) $display("FAIL reset_out16 got=%b/%h want=0/0", vo16, res16); else passed++;
   endtask

   task automatic test_latency();
      int n;
      @(negedge clk);
      rdy8 = 1'b1; v8 = 1'b1; md8 = 8'd7; mr8 = 8'hFD; u8 = 1'b0;
      @(negedge clk);
      v8 = 1'b0;
      n = 1;
      while (!vo8 && n < 20) begin
         @(negedge clk);
         n++;
      end
      $display("latency pair 7*-3: valid after %0d cycles, result %h", n-1, res8);
      checks++; if (n-1 != 5) $display("FAIL latency got=%0d want=5", n-1); else passed++;
      checks++; if (res8 !== 16'hFFEB) $display("FAIL latency_result got=%h want=FFEB", res8); else passed++;
      @(negedge clk);
      checks++; if (vo8 !== 1'b0) $display("FAIL latency_dup got=%b want=0", vo8); else passed++;
   endtask

   task automatic test_corners();
      logic [7:0]  mds [4];
      logic [7:0]  mrs [4];
      logic        us  [4];
      logic [15:0] exps[4];
      int nv, got, cyc;
      mds[0] = 8'h80; mrs[0] = 8'h80; us[0] = 1'b0; exps[0] = 16'h4000;
      mds[1] = 8'hFF; mrs[1] = 8'hFF; us[1] = 1'b0; exps[1] = 16'h0001;
      mds[2] = 8'hFF; mrs[2] = 8'hFF; us[2] = 1'b1; exps[2] = 16'hFE01;
      mds[3] = 8'hFF; mrs[3] = 8'hFF; us[3] = 1'b0; exps[3] = 16'h0001;
      nv = 2;
`ifdef RADIX4_UNSIGNED_EN
      nv = 4;
`endif
      rdy8 = 1'b1;
      for (int i = 0; i < nv; i++) begin
         @(negedge clk);
         v8 = 1'b1; md8 = mds[i]; mr8 = mrs[i]; u8 = us[i];
      end
      got = 0;
      cyc = 0;
      while (got < nv && cyc < 30) begin
         @(negedge clk);
         v8 = 1'b0;
         cyc++;
         if (vo8) begin
            $display("corner %0d: %h*%h uns=%b -> %h", got, mds[got], mrs[got], us[got], res8);
            checks++; if (res8 !== exps[got]) $display("FAIL corner%0d got=%h want=%h", got, res8, exps[got]); else passed++;
            got++;
         end
      end
      checks++; if (got != nv) $display("FAIL corner_count got=%0d want=%0d", got, nv); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] q[$];
      logic [15:0] held, exp_v;
      logic        prev_stall, exp_rdy;
      int sent, got, cyc;
      sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; held = '0;
      while (got < 20 && cyc < 200) begin
         @(negedge clk);
         rdy8 = !(cyc >= 8 && cyc < 11);
         if (sent < 20) begin
            v8 = 1'b1; md8 = 8'($urandom); mr8 = 8'($urandom); u8 = 1'b0;
         end else begin
            v8 = 1'b0;
         end
         #1;
         exp_rdy = rdy8 || !vo8;
         checks++; if (ro8 !== exp_rdy) $display("FAIL b2b_ready cyc=%0d got=%b want=%b", cyc, ro8, exp_rdy); else passed++;
         if (prev_stall) begin
            checks++;
            if (vo8 !== 1'b1 || res8 !== held)
               $display("FAIL b2b_stall_hold cyc=%0d got=%b/%h want=1/%h", cyc, vo8, res8, held);
            else passed++;
         end
         prev_stall = vo8 && !rdy8;
         held = res8;
         if (vo8 && rdy8) begin
            exp_v = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
            $display("b2b result %0d: %h", got, res8);
            checks++; if (res8 !== exp_v) $display("FAIL b2b_result%0d got=%h want=%h", got, res8, exp_v); else passed++;
            got++;
         end
         if (v8 && exp_rdy) begin
            q.push_back(16'(ref_prod(8, {8'h0, md8}, {8'h0, mr8}, 1'b0)));
            sent++;
         end
         cyc++;
      end
      checks++; if (got != 20 || q.size() != 0) $display("FAIL b2b_count got=%0d want=20", got); else passed++;
      v8 = 1'b0; rdy8 = 1'b1;
   endtask

   task automatic test_reset_midflight();
      logic [15:0] exp_v;
      int n;
      @(negedge clk);
      rdy8 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         v8 = 1'b1; md8 = 8'($urandom_range(1, 127)); mr8 = 8'($urandom_range(1, 127)); u8 = 1'b0;
         @(negedge clk);
      end
      v8 = 1'b0;
      n = 0;
      while (!vo8 && n < 20) begin
         @(negedge clk);
         n++;
      end
      #2 rst_n = 1'b0;
      #1;
      $display("midflight reset: valid_o=%b result_o=%h", vo8, res8);
      checks++; if (vo8 !== 1'b0) $display("FAIL midreset_valid got=%b want=0", vo8); else passed++;
      checks++; if (res8 !== 16'h0) $display("FAIL midreset_result got=%h want=0000", res8); else passed++;
      checks++; if (ro8 !== 1'b1) $display("FAIL midreset_ready got=%b want=1", ro8); else passed++;
      @(negedge clk);
      rst_n = 1'b1; rdy8 = 1'b1;
      @(negedge clk);
      v8 = 1'b1; md8 = 8'h5A; mr8 = 8'hC3; u8 = 1'b0;
      exp_v = 16'(ref_prod(8, 16'h005A, 16'h00C3, 1'b0));
      @(negedge clk);
      v8 = 1'b0;
      n = 1;
      while (!vo8 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n-1 != 5) $display("FAIL midreset_first_latency got=%0d want=5", n-1); else passed++;
      checks++; if (res8 !== exp_v) $display("FAIL midreset_first_result got=%h want=%h", res8, exp_v); else passed++;
   endtask

   task automatic test_random16();
      logic [31:0] q[$];
      logic [31:0] exp_v;
      logic [15:0] corner [4];
      logic        exp_rdy;
      int sent, got, cyc, errs;
      corner[0] = 16'h8000; corner[1] = 16'hFFFF; corner[2] = 16'h7FFF; corner[3] = 16'h0000;
      sent = 0; got = 0; cyc = 0; errs = 0;
      while (got < 10000 && cyc < 60000) begin
         @(negedge clk);
         rdy16 = ($urandom_range(0, 3) != 0);
         if (sent < 10000 && $urandom_range(0, 4) != 0) begin
            v16 = 1'b1;
            md16 = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
            mr16 = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
            u16 = 1'b0;
`ifdef RADIX4_UNSIGNED_EN
            u16 = 1'($urandom_range(0, 1));
`endif
         end else begin
            v16 = 1'b0;
         end
         #1;
         exp_rdy = rdy16 || !vo16;
         checks++; if (ro16 !== exp_rdy) $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, ro16, exp_rdy); else passed++;
         if (vo16 && rdy16) begin
            exp_v = (q.size() > 0) ? q.pop_front() : 32'hxxxxxxxx;
            checks++;
            if (res16 !== exp_v) begin
               if (errs < 20) $display("FAIL rnd_result%0d got=%h want=%h", got, res16, exp_v);
               errs++;
            end else passed++;
            got++;
         end
         if (v16 && exp_rdy) begin
            q.push_back(ref_prod(16, md16, mr16, u16));
            sent++;
         end
         cyc++;
      end
      $display("random16: %0d results in %0d cycles", got, cyc);
      checks++; if (got != 10000 || q.size() != 0) $display("FAIL rnd_count got=%0d want=10000", got); else passed++;
      v16 = 1'b0; rdy16 = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      v8 = 1'b0; rdy8 = 1'b0; u8 = 1'b0; md8 = '0; mr8 = '0;
      v16 = 1'b0; rdy16 = 1'b1; u16 = 1'b0; md16 = '0; mr16 = '0;
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_latency();
      test_corners();
      test_back_to_back();
      test_reset_midflight();
      test_random16();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
